// File: rtl/ctrl_pkg.sv
// ctrl_pkg: RV32I opcodes, control-field encodings and the EX-stage control bundle
package ctrl_pkg;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_SLT   = 4'd5;
  localparam logic [3:0] ALU_SLTU  = 4'd6;
  localparam logic [3:0] ALU_SLL   = 4'd7;
  localparam logic [3:0] ALU_SRL   = 4'd8;
  localparam logic [3:0] ALU_SRA   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;
  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_J = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       jump_reg;
    logic       branch;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [2:0] branch_type;
    logic [3:0] alu_ctrl;
    logic [1:0] result_src;
  } ctrl_bundle;
  function automatic logic [3:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
endpackage

// File: rtl/ctrl_decode_comb.sv
// ctrl_decode_comb: combinational RV32I decode of op/funct3/funct7[5] into the control bundle
import ctrl_pkg::*;
module ctrl_decode_comb (
  input  logic [31:0] instr,
  input  logic        valid,
  output ctrl_bundle  ctrl,
  output logic [2:0]  imm_src,
  output logic        illegal
);
  logic [6:0] op;
  logic [2:0] f3;
  logic       f7b5;
  logic       bad;
  logic       unused_bits;
  ctrl_bundle raw;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7b5 = instr[30];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
  always_comb begin
    raw = '0;
    bad = 1'b0;
    imm_src = IMM_I;
    case (op)
      OP_LOAD: begin
        raw.reg_write = 1'b1;
        raw.alu_src_b = 1'b1;
        raw.result_src = RES_MEM;
      end
      OP_STORE: begin
        raw.mem_write = 1'b1;
        raw.alu_src_b = 1'b1;
        imm_src = IMM_S;
      end
      OP_BRANCH: begin
        raw.branch = 1'b1;
        raw.alu_ctrl = ALU_SUB;
        raw.branch_type = f3;
        imm_src = IMM_B;
        bad = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OP_R: begin
        raw.reg_write = 1'b1;
        raw.alu_ctrl = alu_op(f3, f7b5);
        bad = f7b5 && (f3 != 3'b000) && (f3 != 3'b101);
      end
      OP_I: begin
        // funct7[5] is immediate data except on shifts, so only srai/srli look at it
        raw.reg_write = 1'b1;
        raw.alu_src_b = 1'b1;
        raw.alu_ctrl = alu_op(f3, (f3 == 3'b101) && f7b5);
        bad = (f3 == 3'b001) && f7b5;
      end
      OP_JAL: begin
        raw.reg_write = 1'b1;
        raw.jump = 1'b1;
        raw.result_src = RES_PC4;
        imm_src = IMM_J;
      end
      OP_JALR: begin
        raw.reg_write = 1'b1;
        raw.jump = 1'b1;
        raw.jump_reg = 1'b1;
        raw.alu_src_b = 1'b1;
        raw.result_src = RES_PC4;
      end
      OP_LUI: begin
        raw.reg_write = 1'b1;
        raw.alu_src_b = 1'b1;
        raw.alu_ctrl = ALU_PASSB;
        imm_src = IMM_U;
      end
      OP_AUIPC: begin
        raw.reg_write = 1'b1;
        raw.alu_src_a = 1'b1;
        raw.alu_src_b = 1'b1;
        imm_src = IMM_U;
      end
      default: bad = 1'b1;
    endcase
    ctrl = (valid && !bad) ? raw : '0;
    illegal = valid && bad;
  end
endmodule

// File: rtl/ctrl_pipe_decoder.sv
// ctrl_pipe_decoder: RV32I control unit with ID/EX, EX/MEM, MEM/WB control registers
// Optional CTRL_ILLEGAL_TRAP_EN carries an illegal-instruction flag down to illegal_w.
import ctrl_pkg::*;
module ctrl_pipe_decoder #(
  parameter int ALU_CTRL_W   = 4,
  parameter int IMM_SRC_W    = 3,
  parameter int RESULT_SRC_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             instr_d,
  input  logic                    valid_d,
  input  logic                    stall_e,
  input  logic                    flush_e,
  output logic [IMM_SRC_W-1:0]    imm_src_d,
  output logic                    reg_write_e,
  output logic                    mem_write_e,
  output logic                    jump_e,
  output logic                    jump_reg_e,
  output logic                    branch_e,
  output logic                    alu_src_a_e,
  output logic                    alu_src_b_e,
  output logic [2:0]              branch_type_e,
  output logic [ALU_CTRL_W-1:0]   alu_ctrl_e,
  output logic [RESULT_SRC_W-1:0] result_src_e,
  output logic                    reg_write_m,
  output logic                    mem_write_m,
  output logic [RESULT_SRC_W-1:0] result_src_m,
  output logic                    reg_write_w,
  output logic [RESULT_SRC_W-1:0] result_src_w,
  output logic                    illegal_w
);
  ctrl_bundle dec_d, ctl_e;
  logic [2:0] imm_src;
  logic       ill_d;
  logic [1:0] res_m, res_w;
  if (ALU_CTRL_W < 4 || IMM_SRC_W < 3 || RESULT_SRC_W < 2) begin : g_bad_width
    $error("ctrl_pipe_decoder: field width parameter below minimum");
  end
  ctrl_decode_comb u_dec (
    .instr   (instr_d),
    .valid   (valid_d),
    .ctrl    (dec_d),
    .imm_src (imm_src),
    .illegal (ill_d)
  );
  assign imm_src_d = IMM_SRC_W'(imm_src);
  always_ff @(posedge clk) begin
    if (rst || flush_e) ctl_e <= '0;
    else if (!stall_e) ctl_e <= dec_d;
  end
  // EX/MEM takes a bubble while EX is held so the held instruction is not duplicated
  always_ff @(posedge clk) begin
    if (rst || stall_e) {reg_write_m, mem_write_m, res_m} <= '0;
    else {reg_write_m, mem_write_m, res_m} <= {ctl_e.reg_write, ctl_e.mem_write, ctl_e.result_src};
  end
  always_ff @(posedge clk) begin
    if (rst) {reg_write_w, res_w} <= '0;
    else {reg_write_w, res_w} <= {reg_write_m, res_m};
  end
  assign {reg_write_e, mem_write_e, jump_e, jump_reg_e, branch_e, alu_src_a_e, alu_src_b_e} =
    {ctl_e.reg_write, ctl_e.mem_write, ctl_e.jump, ctl_e.jump_reg, ctl_e.branch, ctl_e.alu_src_a, ctl_e.alu_src_b};
  assign branch_type_e = ctl_e.branch_type;
  assign alu_ctrl_e = ALU_CTRL_W'(ctl_e.alu_ctrl);
  assign result_src_e = RESULT_SRC_W'(ctl_e.result_src);
  assign result_src_m = RESULT_SRC_W'(res_m);
  assign result_src_w = RESULT_SRC_W'(res_w);
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic ill_e, ill_m, ill_w;
  always_ff @(posedge clk) begin
    if (rst || flush_e) ill_e <= 1'b0;
    else if (!stall_e) ill_e <= ill_d;
  end
  always_ff @(posedge clk) begin
    ill_m <= (rst || stall_e) ? 1'b0 : ill_e;
    ill_w <= rst ? 1'b0 : ill_m;
  end
  assign illegal_w = ill_w;
`else
  logic unused_ill;
  assign unused_ill = ill_d;
  assign illegal_w = 1'b0;
`endif
endmodule

// File: tb/tb_ctrl_pipe_decoder.sv
// tb_ctrl_pipe_decoder: directed self-checking bench for ctrl_pipe_decoder
module tb_ctrl_pipe_decoder;
`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif
  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h402081B3;
  localparam logic [31:0] I_SRAI  = 32'h4030D293;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_LW    = 32'h0040A303;
  localparam logic [31:0] I_SW    = 32'h0060A423;
  localparam logic [31:0] I_JALR  = 32'h000100E7;
  localparam logic [31:0] I_AUIPC = 32'h00001397;
  localparam logic [31:0] I_BNE   = 32'h00209063;
  logic clk = 1'b0, rst, valid_d, stall_e, flush_e;
  logic [31:0] instr_d;
  logic [2:0] imm_src_d, branch_type_e;
  logic reg_write_e, mem_write_e, jump_e, jump_reg_e, branch_e, alu_src_a_e, alu_src_b_e;
  logic [3:0] alu_ctrl_e;
  logic [1:0] result_src_e, result_src_m, result_src_w;
  logic reg_write_m, mem_write_m, reg_write_w, illegal_w;
  logic [15:0] e_out;
  logic [23:0] all_out;
  int checks = 0, passes = 0, fails = 0;
  logic [31:0] bad_instr [3];
  logic [2:0]  bad_imm [3];
  always #5 clk = ~clk;
  ctrl_pipe_decoder dut (
    .clk(clk), .rst(rst), .instr_d(instr_d), .valid_d(valid_d), .stall_e(stall_e), .flush_e(flush_e),
    .imm_src_d(imm_src_d), .reg_write_e(reg_write_e), .mem_write_e(mem_write_e), .jump_e(jump_e),
    .jump_reg_e(jump_reg_e), .branch_e(branch_e), .alu_src_a_e(alu_src_a_e), .alu_src_b_e(alu_src_b_e),
    .branch_type_e(branch_type_e), .alu_ctrl_e(alu_ctrl_e), .result_src_e(result_src_e),
    .reg_write_m(reg_write_m), .mem_write_m(mem_write_m), .result_src_m(result_src_m),
    .reg_write_w(reg_write_w), .result_src_w(result_src_w), .illegal_w(illegal_w)
  );
  assign e_out = {reg_write_e, mem_write_e, jump_e, jump_reg_e, branch_e, alu_src_a_e, alu_src_b_e,
                  branch_type_e, alu_ctrl_e, result_src_e};
  assign all_out = {e_out, reg_write_m, mem_write_m, result_src_m, reg_write_w, result_src_w, illegal_w};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    bad_instr[0] = 32'h0000007F; bad_imm[0] = 3'd0;
    bad_instr[1] = 32'h00002063; bad_imm[1] = 3'd2;
    bad_instr[2] = 32'h40001013; bad_imm[2] = 3'd0;
    rst = 1'b1; valid_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0; instr_d = '0;
    tick; tick;
    chk("reset_all", 32'(all_out), 0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("idle_all", 32'(all_out), 0);
    end
    valid_d = 1'b1; instr_d = I_ADD; tick;
    chk("add_alu", 32'(alu_ctrl_e), 0);
    chk("add_rw", 32'(reg_write_e), 1);
    instr_d = I_SUB; tick;
    chk("sub_alu", 32'(alu_ctrl_e), 1);
    instr_d = I_SRAI; tick;
    chk("srai_alu", 32'(alu_ctrl_e), 9);
    chk("srai_srcb", 32'(alu_src_b_e), 1);
    instr_d = I_LUI; tick;
    chk("lui_alu", 32'(alu_ctrl_e), 10);
    chk("lui_srcb", 32'(alu_src_b_e), 1);
    instr_d = I_LW; tick;
    chk("lw_res_e", 32'(result_src_e), 1);
    valid_d = 1'b0; tick;
    chk("lw_m", 32'({reg_write_m, result_src_m}), 32'h5);
    chk("lw_w_early", 32'(result_src_w), 0);
    tick;
    chk("lw_w", 32'({reg_write_w, result_src_w}), 32'h5);
    valid_d = 1'b1; instr_d = I_BNE; tick;
    chk("bne_e", 32'({branch_e, branch_type_e, alu_ctrl_e, reg_write_e}), {1'b1, 3'd1, 4'd1, 1'b0});
    instr_d = I_JALR; #1;
    chk("jalr_imm", 32'(imm_src_d), 0);
    tick;
    chk("jalr_e", 32'({jump_e, jump_reg_e, result_src_e, alu_src_b_e}), {1'b1, 1'b1, 2'd2, 1'b1});
    instr_d = I_AUIPC; #1;
    chk("auipc_imm", 32'(imm_src_d), 4);
    tick;
    chk("auipc_e", 32'({alu_src_a_e, alu_src_b_e, alu_ctrl_e}), {1'b1, 1'b1, 4'd0});
    instr_d = I_LW; tick;
    stall_e = 1'b1; instr_d = I_ADD;
    for (int i = 0; i < 2; i++) begin
      tick;
      chk("stall_e_held", 32'({reg_write_e, result_src_e}), 32'h5);
      chk("stall_m_bubble", 32'({reg_write_m, mem_write_m, result_src_m}), 0);
    end
    flush_e = 1'b1; tick;
    chk("flush_e", 32'(e_out), 0);
    stall_e = 1'b0; flush_e = 1'b0; valid_d = 1'b0; tick; tick; tick;
    chk("drained", 32'(all_out), 0);
    for (int k = 0; k < 3; k++) begin
      valid_d = 1'b1; instr_d = bad_instr[k]; #1;
      chk("ill_imm", 32'(imm_src_d), 32'(bad_imm[k]));
      tick;
      chk("ill_e", 32'(all_out), 0);
      valid_d = 1'b0; tick;
      chk("ill_m", 32'(all_out), 0);
      tick;
      chk("ill_w", 32'(all_out), 32'(TRAP));
      tick;
      chk("ill_after", 32'(all_out), 0);
    end
    valid_d = 1'b1; instr_d = I_SW; tick;
    chk("sw_e", 32'({mem_write_e, reg_write_e}), 32'h2);
    instr_d = I_LW; tick;
    chk("sw_m", 32'(mem_write_m), 1);
    rst = 1'b1; stall_e = 1'b1; valid_d = 1'b0; tick;
    chk("rst_mid", 32'(all_out), 0);
    rst = 1'b0; stall_e = 1'b0; tick;
    chk("post_rst", 32'(all_out), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
